conv_mem_loader: RTL and testbench

- Front-end writer that fills the convolution engine's filter memory and picture memory from an external valid/ready word stream.
- Once both memories are loaded, it produces the start_everything handshake the convolution controller expects: high, then low.
- It then waits for the engine's done and reports completion.
- Sits between the host/testbench stream and the two input memories, upstream of the convolution controller.

---
 rtl/conv_pkg.sv | 15 +
 rtl/conv_mem_loader_if.sv | 12 +
 rtl/conv_mem_loader_wr_stage.sv | 43 ++++
 rtl/conv_mem_loader.sv | 156 +++++++++++++++
 tb/tb_conv_mem_loader.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state encoding and defaults for the convolution front end
package conv_pkg;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 8;
   localparam int FILTER_WORDS   = 4;

   typedef enum logic [2:0] {
      LDR_IDLE      = 3'd0,
      LDR_LD_FILT   = 3'd1,
      LDR_LD_PIC    = 3'd2,
      LDR_START_HI  = 3'd3,
      LDR_START_LO  = 3'd4,
      LDR_WAIT_DONE = 3'd5
   } ldr_state_t;
endpackage

// File: rtl/conv_mem_loader_if.sv
// rtl/conv_mem_loader_if.sv - valid/ready word stream feeding the memory loader
interface conv_mem_loader_if import conv_pkg::*; #(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();
   logic                  s_valid;
   logic                  s_ready;
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_last;

   modport master (output s_valid, output s_data, output s_last, input s_ready);
   modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/conv_mem_loader_wr_stage.sv
// rtl/conv_mem_loader_wr_stage.sv - registered write stage driving both input memories
module ldr_wr_stage import conv_pkg::*; #(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_filt_en,
   input  logic                  i_pic_en,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_filt_we,
   output logic                  o_pic_we,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic [DATA_WIDTH-1:0] o_data
);
   logic                  r_filt_we;
   logic                  r_pic_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_data;

   // One-cycle write pipeline; address/data hold their last value between writes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_filt_we <= 1'b0;
         r_pic_we  <= 1'b0;
         r_addr    <= '0;
         r_data    <= '0;
      end else begin
         r_filt_we <= i_filt_en;
         r_pic_we  <= i_pic_en;
         if (i_filt_en || i_pic_en) begin
            r_addr <= i_addr;
            r_data <= i_data;
         end
      end
   end

   assign o_filt_we = r_filt_we;
   assign o_pic_we  = r_pic_we;
   assign o_addr    = r_addr;
   assign o_data    = r_data;
endmodule

// File: rtl/conv_mem_loader.sv
// rtl/conv_mem_loader.sv - loads filter and picture memories then runs the start/done handshake
module conv_mem_loader import conv_pkg::*; #(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int NUMBER_OF_CONV = 2,
   parameter int PIC_WORDS      = 64,
   parameter int START_CYCLES   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   conv_mem_loader_if.slave      s_if,
   input  logic                  i_load_req,
   output logic                  o_filt_we,
   output logic                  o_pic_we,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [DATA_WIDTH-1:0] o_mem_wdata,
   output logic                  o_start_everything,
   input  logic                  i_conv_done,
   output logic                  o_busy,
   output logic                  o_finished,
   output logic                  o_len_err
);
   localparam int FILT_TOTAL = FILTER_WORDS * NUMBER_OF_CONV;
   localparam int SCW        = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
   localparam logic [ADDR_WIDTH-1:0] FILT_LAST  = ADDR_WIDTH'(FILT_TOTAL - 1);
   localparam logic [ADDR_WIDTH-1:0] PIC_LAST   = ADDR_WIDTH'(PIC_WORDS - 1);
   localparam logic [SCW-1:0]        START_LAST = SCW'(START_CYCLES - 1);

   if (FILT_TOTAL > 2**ADDR_WIDTH) begin : g_chk_filt
      $error("filter words do not fit the address range");
   end
   if (PIC_WORDS > 2**ADDR_WIDTH) begin : g_chk_pic
      $error("picture words do not fit the address range");
   end
   if (START_CYCLES < 1) begin : g_chk_start
      $error("start pulse must last at least one cycle");
   end

   ldr_state_t            r_state;
   logic [ADDR_WIDTH-1:0] r_count;
   logic [SCW-1:0]        r_start_cnt;
   logic                  r_start;
   logic                  r_busy;
   logic                  r_finished;
   logic                  r_len_err;
   logic                  w_accept;
   logic                  w_filt_en;
   logic                  w_pic_en;

   assign s_if.s_ready = (r_state == LDR_LD_FILT) || (r_state == LDR_LD_PIC);
   assign w_accept     = s_if.s_valid && s_if.s_ready;
   assign w_filt_en    = w_accept && (r_state == LDR_LD_FILT);
   assign w_pic_en     = w_accept && (r_state == LDR_LD_PIC);

   // Load sequencing, start handshake and completion tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= LDR_IDLE;
         r_count     <= '0;
         r_start_cnt <= '0;
         r_start     <= 1'b0;
         r_busy      <= 1'b0;
         r_finished  <= 1'b0;
         r_len_err   <= 1'b0;
      end else begin
         r_finished <= 1'b0;
         case (r_state)
            LDR_IDLE: begin
               if (i_load_req) begin
                  r_state   <= LDR_LD_FILT;
                  r_count   <= '0;
                  r_len_err <= 1'b0;
                  r_busy    <= 1'b1;
               end
            end
            LDR_LD_FILT: begin
               if (w_accept) begin
                  // A premature last beat outranks the filter-to-picture boundary
                  if (s_if.s_last) begin
                     r_len_err <= 1'b1;
                     r_state   <= LDR_IDLE;
                     r_busy    <= 1'b0;
                  end else if (r_count == FILT_LAST) begin
                     r_count <= '0;
                     r_state <= LDR_LD_PIC;
                  end else begin
                     r_count <= r_count + ADDR_WIDTH'(1);
                  end
               end
            end
            LDR_LD_PIC: begin
               if (w_accept) begin
                  if (r_count == PIC_LAST) begin
                     // Missing last marker is flagged but the picture is complete
                     if (!s_if.s_last) r_len_err <= 1'b1;
                     r_state     <= LDR_START_HI;
                     r_start     <= 1'b1;
                     r_start_cnt <= '0;
                  end else if (s_if.s_last) begin
                     r_len_err <= 1'b1;
                     r_state   <= LDR_IDLE;
                     r_busy    <= 1'b0;
                  end else begin
                     r_count <= r_count + ADDR_WIDTH'(1);
                  end
               end
            end
            LDR_START_HI: begin
               if (r_start_cnt == START_LAST) begin
                  r_start <= 1'b0;
                  r_state <= LDR_START_LO;
               end else begin
                  r_start_cnt <= r_start_cnt + SCW'(1);
               end
            end
            LDR_START_LO: begin
               // One low cycle so the controller always sees the falling edge
               r_state <= LDR_WAIT_DONE;
            end
            LDR_WAIT_DONE: begin
               if (i_conv_done) begin
                  r_finished <= 1'b1;
                  r_busy     <= 1'b0;
                  r_state    <= LDR_IDLE;
               end
            end
            default: begin
               r_state <= LDR_IDLE;
               r_start <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   ldr_wr_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_wr_stage (
      .clk       (clk),
      .rst       (rst),
      .i_filt_en (w_filt_en),
      .i_pic_en  (w_pic_en),
      .i_addr    (r_count),
      .i_data    (s_if.s_data),
      .o_filt_we (o_filt_we),
      .o_pic_we  (o_pic_we),
      .o_addr    (o_mem_addr),
      .o_data    (o_mem_wdata)
   );

   assign o_start_everything = r_start;
   assign o_busy             = r_busy;
   assign o_finished         = r_finished;
   assign o_len_err          = r_len_err;
endmodule

// File: tb/tb_conv_mem_loader.sv
// tb/tb_conv_mem_loader.sv - randomized self-checking bench for conv_mem_loader
module tb_conv_mem_loader;
   localparam int DW  = 32;
   localparam int AW  = 8;
   localparam int NC  = 2;
   localparam int PW  = 64;
   localparam int SC  = 2;
   localparam int FW  = 4 * NC;
   localparam int TOT = FW + PW;

   typedef struct {
      bit            filt;
      int            addr;
      logic [DW-1:0] data;
      int            cyc;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          load_req = 1'b0;
   logic          conv_done = 1'b0;
   logic          filt_we, pic_we, start_everything, busy, finished, len_err;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;

   conv_mem_loader_if #(.DATA_WIDTH(DW)) s_if ();

   conv_mem_loader #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUMBER_OF_CONV(NC),
      .PIC_WORDS(PW), .START_CYCLES(SC)
   ) dut (
      .clk(clk), .rst(rst), .s_if(s_if), .i_load_req(load_req),
      .o_filt_we(filt_we), .o_pic_we(pic_we), .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata), .o_start_everything(start_everything),
      .i_conv_done(conv_done), .o_busy(busy), .o_finished(finished),
      .o_len_err(len_err)
   );

   always #5 clk = ~clk;

   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;
   wr_t           wr_q[$];
   wr_t           exp_q[$];
   int            acc_q[$];
   int            start_hi_cnt, start_rise, fin_cnt;
   logic [DW-1:0] beat_data[$];
   bit            beat_last[$];
   bit            exp_err, exp_start;

   always @(posedge clk) cyc <= cyc + 1;

   // Observe DUT outputs on the falling edge, away from the active edge
   always @(negedge clk) begin
      if (filt_we || pic_we) wr_q.push_back('{filt_we, int'(mem_addr), mem_wdata, cyc});
      if (s_if.s_valid && s_if.s_ready) acc_q.push_back(cyc);
      if (start_everything) begin
         if (start_hi_cnt == 0) start_rise = cyc;
         start_hi_cnt++;
      end
      if (finished) fin_cnt++;
   end

   task automatic clear_mon();
      wr_q.delete();
      acc_q.delete();
      start_hi_cnt = 0;
      start_rise   = -1;
      fin_cnt      = 0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      wait_cycles(2);
      rst = 1'b0;
      wait_cycles(1);
   endtask

   task automatic make_beats(input int n, input bit rnd, input int last_idx);
      beat_data.delete();
      beat_last.delete();
      for (int i = 0; i < n; i++) begin
         beat_data.push_back(rnd ? DW'($urandom) : DW'(i));
         beat_last.push_back(i == last_idx);
      end
   endtask

   // Reference: beat i goes to filter word i or picture word i-FW; stream stops on any early last
   function automatic void build_model();
      exp_q.delete();
      exp_err   = 1'b0;
      exp_start = 1'b0;
      for (int i = 0; i < beat_data.size(); i++) begin
         exp_q.push_back('{(i < FW), (i < FW) ? i : i - FW, beat_data[i], 0});
         if (i == TOT - 1) begin
            exp_start = 1'b1;
            exp_err   = !beat_last[i];
            break;
         end
         if (beat_last[i]) begin
            exp_err = 1'b1;
            break;
         end
      end
   endfunction

   task automatic do_load();
      load_req = 1'b1;
      wait_cycles(1);
      load_req = 1'b0;
   endtask

   task automatic drive_stream(input int gap_pct, input int req_at);
      for (int i = 0; i < beat_data.size(); i++) begin
         int  t;
         bit  acc;
         while ($urandom_range(99) < gap_pct) begin
            s_if.s_valid = 1'b0;
            wait_cycles(1);
         end
         s_if.s_valid = 1'b1;
         s_if.s_data  = beat_data[i];
         s_if.s_last  = beat_last[i];
         if (i == req_at) load_req = 1'b1;
         t = 0;
         forever begin
            @(negedge clk);
            acc = s_if.s_ready;
            wait_cycles(1);
            load_req = 1'b0;
            if (acc) break;
            t++;
            if (t > 50) begin
               checks++;
               errors++;
               $display("FAIL stream_timeout beat %0d not accepted within 50 cycles, required acceptance", i);
               s_if.s_valid = 1'b0;
               s_if.s_last  = 1'b0;
               return;
            end
         end
      end
      s_if.s_valid = 1'b0;
      s_if.s_last  = 1'b0;
   endtask

   task automatic test_reset();
      wait_cycles(3);
      checks++;
      if ({filt_we, pic_we, mem_addr, mem_wdata, start_everything, busy, finished, len_err, s_if.s_ready} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got we=%b%b addr=%0d data=%h st=%b busy=%b fin=%b err=%b rdy=%b required all 0",
                  filt_we, pic_we, mem_addr, mem_wdata, start_everything, busy, finished, len_err, s_if.s_ready);
      end
      rst = 1'b0;
      wait_cycles(1);
      checks++;
      if (busy !== 1'b0 || s_if.s_ready !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset got busy=%b rdy=%b required 0 0", busy, s_if.s_ready);
      end
   endtask

   task automatic test_nominal();
      make_beats(TOT, 1'b0, TOT - 1);
      build_model();
      clear_mon();
      do_load();
      checks++;
      if (busy !== 1'b1 || s_if.s_ready !== 1'b1) begin
         errors++;
         $display("FAIL nom_busy got busy=%b rdy=%b required 1 1", busy, s_if.s_ready);
      end
      drive_stream(0, -1);
      wait_cycles(6);
      checks++;
      if (wr_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL nom_wr_count got %0d required %0d", wr_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < wr_q.size() && i < acc_q.size()) begin
         checks++;
         if (wr_q[i].filt !== exp_q[i].filt || wr_q[i].addr !== exp_q[i].addr ||
             wr_q[i].data !== exp_q[i].data || wr_q[i].cyc - acc_q[i] != 1) begin
            errors++;
            $display("FAIL nom_wr[%0d] got filt=%0d addr=%0d data=%h lat=%0d required filt=%0d addr=%0d data=%h lat=1",
                     i, wr_q[i].filt, wr_q[i].addr, wr_q[i].data, wr_q[i].cyc - acc_q[i],
                     exp_q[i].filt, exp_q[i].addr, exp_q[i].data);
         end
      end
      checks++;
      if (start_hi_cnt != SC || start_everything !== 1'b0) begin
         errors++;
         $display("FAIL nom_start got high_cycles=%0d now=%b required %0d 0", start_hi_cnt, start_everything, SC);
      end
      if (wr_q.size() > 0) begin
         checks++;
         if (start_rise != wr_q[wr_q.size() - 1].cyc) begin
            errors++;
            $display("FAIL nom_start_rise got cycle %0d required %0d", start_rise, wr_q[wr_q.size() - 1].cyc);
         end
      end
      wait_cycles(14);
      checks++;
      if (fin_cnt != 0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL nom_wait got fin=%0d busy=%b required 0 1", fin_cnt, busy);
      end
      conv_done = 1'b1;
      wait_cycles(1);
      conv_done = 1'b0;
      wait_cycles(3);
      checks++;
      if (fin_cnt != 1 || busy !== 1'b0 || len_err !== 1'b0) begin
         errors++;
         $display("FAIL nom_done got fin=%0d busy=%b err=%b required 1 0 0", fin_cnt, busy, len_err);
      end
   endtask

   task automatic test_gaps();
      make_beats(TOT, 1'b1, TOT - 1);
      build_model();
      clear_mon();
      do_load();
      drive_stream(50, -1);
      wait_cycles(6);
      checks++;
      if (wr_q.size() != exp_q.size() || acc_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL gap_wr_count got wr=%0d acc=%0d required %0d", wr_q.size(), acc_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < wr_q.size() && i < acc_q.size()) begin
         checks++;
         if (wr_q[i].filt !== exp_q[i].filt || wr_q[i].addr !== exp_q[i].addr ||
             wr_q[i].data !== exp_q[i].data || wr_q[i].cyc - acc_q[i] != 1) begin
            errors++;
            $display("FAIL gap_wr[%0d] got filt=%0d addr=%0d data=%h lat=%0d required filt=%0d addr=%0d data=%h lat=1",
                     i, wr_q[i].filt, wr_q[i].addr, wr_q[i].data, wr_q[i].cyc - acc_q[i],
                     exp_q[i].filt, exp_q[i].addr, exp_q[i].data);
         end
      end
      conv_done = 1'b1;
      wait_cycles(1);
      conv_done = 1'b0;
      wait_cycles(2);
      checks++;
      if (start_hi_cnt != SC || fin_cnt != 1 || busy !== 1'b0 || len_err !== exp_err) begin
         errors++;
         $display("FAIL gap_done got start=%0d fin=%0d busy=%b err=%b required %0d 1 0 %b",
                  start_hi_cnt, fin_cnt, busy, len_err, SC, exp_err);
      end
   endtask

   task automatic test_early_last();
      make_beats(FW + 11, 1'b1, FW + 10);
      build_model();
      clear_mon();
      do_load();
      drive_stream(20, -1);
      wait_cycles(6);
      checks++;
      if (wr_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL early_wr_count got %0d required %0d", wr_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < wr_q.size()) begin
         checks++;
         if (wr_q[i].filt !== exp_q[i].filt || wr_q[i].addr !== exp_q[i].addr || wr_q[i].data !== exp_q[i].data) begin
            errors++;
            $display("FAIL early_wr[%0d] got filt=%0d addr=%0d data=%h required filt=%0d addr=%0d data=%h",
                     i, wr_q[i].filt, wr_q[i].addr, wr_q[i].data, exp_q[i].filt, exp_q[i].addr, exp_q[i].data);
         end
      end
      checks++;
      if (len_err !== exp_err || busy !== 1'b0 || s_if.s_ready !== 1'b0 || start_hi_cnt != 0) begin
         errors++;
         $display("FAIL early_state got err=%b busy=%b rdy=%b start=%0d required %b 0 0 0",
                  len_err, busy, s_if.s_ready, start_hi_cnt, exp_err);
      end
      do_load();
      checks++;
      if (len_err !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL early_clear got err=%b busy=%b required 0 1", len_err, busy);
      end
      apply_reset();
   endtask

   task automatic test_missing_last();
      make_beats(TOT, 1'b1, -1);
      build_model();
      clear_mon();
      do_load();
      drive_stream(10, -1);
      wait_cycles(6);
      checks++;
      if (wr_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL miss_wr_count got %0d required %0d", wr_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < wr_q.size()) begin
         checks++;
         if (wr_q[i].filt !== exp_q[i].filt || wr_q[i].addr !== exp_q[i].addr || wr_q[i].data !== exp_q[i].data) begin
            errors++;
            $display("FAIL miss_wr[%0d] got filt=%0d addr=%0d data=%h required filt=%0d addr=%0d data=%h",
                     i, wr_q[i].filt, wr_q[i].addr, wr_q[i].data, exp_q[i].filt, exp_q[i].addr, exp_q[i].data);
         end
      end
      checks++;
      if (len_err !== exp_err || start_hi_cnt != (exp_start ? SC : 0) || busy !== 1'b1) begin
         errors++;
         $display("FAIL miss_state got err=%b start=%0d busy=%b required %b %0d 1",
                  len_err, start_hi_cnt, busy, exp_err, exp_start ? SC : 0);
      end
      conv_done = 1'b1;
      wait_cycles(1);
      conv_done = 1'b0;
      wait_cycles(2);
      checks++;
      if (fin_cnt != 1 || busy !== 1'b0 || len_err !== 1'b1) begin
         errors++;
         $display("FAIL miss_done got fin=%0d busy=%b err=%b required 1 0 1", fin_cnt, busy, len_err);
      end
   endtask

   task automatic test_load_req_ignored();
      make_beats(TOT, 1'b1, TOT - 1);
      build_model();
      clear_mon();
      do_load();
      drive_stream(30, FW + 20);
      wait_cycles(6);
      checks++;
      if (wr_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL ign_wr_count got %0d required %0d", wr_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < wr_q.size()) begin
         checks++;
         if (wr_q[i].filt !== exp_q[i].filt || wr_q[i].addr !== exp_q[i].addr || wr_q[i].data !== exp_q[i].data) begin
            errors++;
            $display("FAIL ign_wr[%0d] got filt=%0d addr=%0d data=%h required filt=%0d addr=%0d data=%h",
                     i, wr_q[i].filt, wr_q[i].addr, wr_q[i].data, exp_q[i].filt, exp_q[i].addr, exp_q[i].data);
         end
      end
      do_load();
      wait_cycles(2);
      checks++;
      if (busy !== 1'b1 || s_if.s_ready !== 1'b0 || fin_cnt != 0 || start_hi_cnt != SC) begin
         errors++;
         $display("FAIL ign_wait got busy=%b rdy=%b fin=%0d start=%0d required 1 0 0 %0d",
                  busy, s_if.s_ready, fin_cnt, start_hi_cnt, SC);
      end
      conv_done = 1'b1;
      wait_cycles(10);
      conv_done = 1'b0;
      wait_cycles(2);
      checks++;
      if (fin_cnt != 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL ign_done got fin=%0d busy=%b required 1 0", fin_cnt, busy);
      end
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] d0;
      make_beats(FW + 31, 1'b1, -1);
      clear_mon();
      do_load();
      drive_stream(0, -1);
      checks++;
      if (pic_we !== 1'b1 || mem_addr !== AW'(30)) begin
         errors++;
         $display("FAIL mid_before got pic_we=%b addr=%0d required 1 30", pic_we, mem_addr);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({filt_we, pic_we, mem_addr, mem_wdata, start_everything, busy, finished, len_err, s_if.s_ready} !== '0) begin
         errors++;
         $display("FAIL mid_async got we=%b%b addr=%0d data=%h st=%b busy=%b fin=%b err=%b rdy=%b required all 0",
                  filt_we, pic_we, mem_addr, mem_wdata, start_everything, busy, finished, len_err, s_if.s_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      wait_cycles(1);
      make_beats(1, 1'b1, -1);
      d0 = beat_data[0];
      clear_mon();
      do_load();
      drive_stream(0, -1);
      wait_cycles(2);
      checks++;
      if (wr_q.size() != 1) begin
         errors++;
         $display("FAIL mid_restart_count got %0d required 1", wr_q.size());
      end else begin
         checks++;
         if (wr_q[0].filt !== 1'b1 || wr_q[0].addr != 0 || wr_q[0].data !== d0) begin
            errors++;
            $display("FAIL mid_restart got filt=%0d addr=%0d data=%h required filt=1 addr=0 data=%h",
                     wr_q[0].filt, wr_q[0].addr, wr_q[0].data, d0);
         end
      end
      apply_reset();
   endtask

   initial begin
      s_if.s_valid = 1'b0;
      s_if.s_data  = '0;
      s_if.s_last  = 1'b0;
      clear_mon();
      test_reset();
      test_nominal();
      test_gaps();
      test_early_last();
      test_missing_last();
      test_load_req_ignored();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
